spi_level_ctrl: RTL
===================

Name: spi_level_ctrl

Overview:
Slave-side command receiver that sits directly upstream of the PWM generator and drives its 4-bit level input.
- Accepts 16-bit SPI frames from the master board and decodes level commands.
- Validates each command against the 0..9 power range.
- Ramps the delivered level one step at a time toward the commanded target, so the PWM never jumps more than one level per ramp interval.
- Returns a status byte to the master on MISO.

Parameters:
RAMP_TICKS, 50000, clock cycles between successive one-step changes of level_out; 0 means level_out follows target on the next cycle
MAX_LEVEL, 9, highest legal power level
SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2)

Ports:
clock  input  1  system clock; must be at least 8x spi_sclk
reset  input  1  asynchronous, active-high
spi_sclk  input  1  SPI clock from master, mode 0, asynchronous to clock
spi_cs_n  input  1  SPI chip select, active-low, asynchronous
spi_mosi  input  1  SPI data in, MSB first
spi_miso  output  1  SPI data out, MSB first
level_out  output  4  current delivered level, feeds the PWM level input
target_out  output  4  commanded target level
busy  output  1  high while level_out != target_out
frame_valid  output  1  one-cycle pulse when a legal frame has been executed
frame_err  output  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset values: level_out=0, target_out=0, busy=0, frame_valid=0, frame_err=0, spi_miso=0, err_sticky=0, FSM=IDLE, bit_cnt=0, ramp counter=0.
- Reset asserted mid-frame aborts the frame; no command executes; the first frame after reset release starts clean.
- Input sync: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edge detect runs on the synchronized sclk and cs_n. All decisions use synchronized signals.
- Frame format: byte0 = opcode, byte1 = data, 16 bits MSB first. MOSI is sampled on sclk rising edge; MISO changes on sclk falling edge.
- Opcodes:
  - 0xA1 SET: target = data[3:0]. Legal only if data <= MAX_LEVEL; otherwise error.
  - 0xA2 INC: target+1, saturating at MAX_LEVEL; saturation is not an error. Data byte ignored.
  - 0xA3 DEC: target-1, saturating at 0; saturation is not an error. Data byte ignored.
  - 0xA4 CLR: clears err_sticky. Target unchanged.
  - Any other opcode: error.
- FSM states:
  - IDLE: on cs_n falling edge, load the MISO shift register with status {err_sticky, busy, 2'b00, level_out}, clear bit_cnt, go to SHIFT.
  - SHIFT: each sclk rise shifts mosi in and increments bit_cnt; bit_cnt saturates at 17. Each sclk fall shifts MISO out; after 8 bits MISO outputs 0.
  - SHIFT exit on cs_n rising edge: bit_cnt==16 goes to EXEC; any other count pulses frame_err, sets err_sticky, and returns to IDLE with no state change.
  - EXEC (1 cycle): decode the frame. Legal frame: update target_out, pulse frame_valid. Illegal frame: pulse frame_err, set err_sticky, leave target unchanged. Return to IDLE.
- Latency: frame_valid or frame_err and the target_out update occur SYNC_STAGES+2 clock cycles after the raw cs_n rise. frame_valid and frame_err are never high together.
- spi_miso is driven only while cs_n is low; it holds 0 otherwise.
- Ramp:
  - While target_out != level_out, the ramp counter counts 0..RAMP_TICKS-1. On terminal count, level_out moves one step toward target and the counter clears.
  - When equal, the counter is held at 0.
  - A target change mid-ramp redirects the direction immediately without clearing the counter.
  - busy = (level_out != target_out), registered.
- level_out never exceeds MAX_LEVEL; widths are 4 bits unsigned throughout.

Decomposition:
- Package pwm_ctrl_pkg:
  - opcode enum (OP_SET, OP_INC, OP_DEC, OP_CLR)
  - MAX_LEVEL_DEFAULT
  - status byte bit positions
  - FSM state enum (IDLE, SHIFT, EXEC)
- One sub-module, spi_sync_edge: SYNC_STAGES-flop synchronizer with registered rise/fall pulse outputs. Instantiated for sclk and cs_n; mosi uses the synchronizer only.

Test Plan:
- Reset, then frame 0xA1 0x07 with RAMP_TICKS=4 -> target_out=7, frame_valid pulses once, busy=1. level_out steps 0→7 every 4 cycles and is 7 after 28 cycles, then busy=0.
- With level 9, send 0xA2 0x00 -> frame_valid pulses, target stays 9, no frame_err. With level 0, send 0xA3 -> target stays 0.
- Send 0xA1 0x0C -> frame_err pulses, target unchanged. The next frame's MISO byte0 = 0x80|level. After 0xA4, the following MISO byte0 has bit7=0.
- Raise cs_n after 11 bits -> frame_err pulses, no target change. Send 18 bits -> frame_err pulses.
- With RAMP_TICKS=4, ramp 0→8 and issue SET 2 when level_out=5 -> level_out reverses to 2 without overshoot; busy stays high until level_out==2.
- Assert reset mid-frame at bit 9, release, then send 0xA1 0x03 -> all outputs at 0 during reset; the new frame is accepted and target_out=3.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the SPI level controller.
package pwm_ctrl_pkg;

  // Command opcodes carried in the first byte of a frame.
  typedef enum logic [7:0] {
    OpSet = 8'hA1,
    OpInc = 8'hA2,
    OpDec = 8'hA3,
    OpClr = 8'hA4
  } opcode_e;

  // Frame receiver states.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StExec
  } state_e;

  localparam int unsigned MaxLevelDefault = 9;
  localparam int unsigned FrameBits       = 16;
  localparam int unsigned BitCntMax       = 17;

  // Status byte layout returned on MISO: {err_sticky, busy, 2'b00, level[3:0]}.
  localparam int unsigned StatErrBit   = 7;
  localparam int unsigned StatBusyBit  = 6;
  localparam int unsigned StatLevelMsb = 3;

  function automatic logic [7:0] status_byte(input logic err, input logic busy,
                                             input logic [3:0] level);
    logic [7:0] s;
    s                  = 8'h00;
    s[StatErrBit]      = err;
    s[StatBusyBit]     = busy;
    s[StatLevelMsb:0]  = level;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses.
// The pulses are computed from the last two synchronizer stages so they line up
// with the cycle in which the synchronized level itself changes.
module spi_sync_edge #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              rise_q;
  logic              fall_q;

  // Shift the async input through the chain and flag level changes at the output stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {Stages{RstVal}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      rise_q <= sync_q[Stages-2] & ~sync_q[Stages-1];
      fall_q <= ~sync_q[Stages-2] & sync_q[Stages-1];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_level_ctrl.sv
// SPI slave that receives level commands and ramps the PWM level toward the
// commanded target one step per ramp interval. Returns a status byte on MISO.
module spi_level_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_TICKS  = 50000,
  parameter int unsigned MAX_LEVEL   = MaxLevelDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [3:0] level_out,
  output logic [3:0] target_out,
  output logic       busy,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam logic [3:0] MaxLvl  = 4'(MAX_LEVEL);
  localparam logic [7:0] MaxData = 8'(MAX_LEVEL);
  localparam int unsigned TermInt = (RAMP_TICKS == 0) ? 0 : RAMP_TICKS - 1;
  localparam int unsigned CntW    = (TermInt > 0) ? $clog2(TermInt + 1) : 1;
  localparam logic [CntW-1:0] Term = CntW'(TermInt);

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(
    .Stages (SYNC_STAGES),
    .RstVal (1'b0)
  ) u_sync_sclk (
    .clock  (clock),
    .reset  (reset),
    .d_i    (spi_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // cs_n idles high, so its chain resets high to avoid a false edge at release.
  spi_sync_edge #(
    .Stages (SYNC_STAGES),
    .RstVal (1'b1)
  ) u_sync_cs (
    .clock  (clock),
    .reset  (reset),
    .d_i    (spi_cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI needs the same delay as sclk so it is sampled with the matching rise pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [4:0]      bit_cnt_q;
  logic [15:0]     frame_q;
  logic [7:0]      miso_sh_q;
  logic [3:0]      target_q, target_d;
  logic            err_sticky_q;
  logic            frame_valid_q, frame_err_q;
  logic [3:0]      level_q, level_d;
  logic [CntW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic            busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // Frame decode
  // ---------------------------------------------------------------------------
  logic [7:0] opcode, data;
  logic       exec_ok;
  logic       exec_clr;
  logic [3:0] exec_target;

  assign opcode = frame_q[15:8];
  assign data   = frame_q[7:0];

  // Decode the received frame; a wrong bit count is rejected like a bad opcode.
  always_comb begin
    exec_ok     = 1'b0;
    exec_clr    = 1'b0;
    exec_target = target_q;
    if (bit_cnt_q == 5'(FrameBits)) begin
      case (opcode)
        OpSet: begin
          if (data <= MaxData) begin
            exec_ok     = 1'b1;
            exec_target = data[3:0];
          end
        end
        OpInc: begin
          exec_ok     = 1'b1;
          exec_target = (target_q >= MaxLvl) ? MaxLvl : target_q + 4'd1;
        end
        OpDec: begin
          exec_ok     = 1'b1;
          exec_target = (target_q == 4'd0) ? 4'd0 : target_q - 4'd1;
        end
        OpClr: begin
          exec_ok  = 1'b1;
          exec_clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Target only moves in EXEC on a legal frame.
  always_comb begin
    target_d = target_q;
    if (state_q == StExec && exec_ok) begin
      target_d = exec_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver FSM. Every cs_n rise passes through EXEC so that accept and
  // reject pulses share the same latency from the end of the frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      frame_q       <= '0;
      miso_sh_q     <= '0;
      target_q      <= '0;
      err_sticky_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      target_q      <= target_d;
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            miso_sh_q <= status_byte(err_sticky_q, busy_q, level_q);
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (cs_rise) begin
            miso_sh_q <= '0;
            state_q   <= StExec;
          end else begin
            if (sclk_rise) begin
              frame_q <= {frame_q[14:0], mosi_s};
              if (bit_cnt_q != 5'(BitCntMax)) begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
            // Zero fill: after the status byte MISO reads back as 0.
            if (sclk_fall) begin
              miso_sh_q <= {miso_sh_q[6:0], 1'b0};
            end
          end
        end
        StExec: begin
          if (exec_ok) begin
            frame_valid_q <= 1'b1;
            if (exec_clr) begin
              err_sticky_q <= 1'b0;
            end
          end else begin
            frame_err_q  <= 1'b1;
            err_sticky_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Level ramp
  // ---------------------------------------------------------------------------
  // Step level one unit toward target on each terminal count; direction follows
  // the current target so a mid-ramp change reverses without clearing the count.
  always_comb begin
    level_d    = level_q;
    ramp_cnt_d = '0;
    if (RAMP_TICKS == 0) begin
      level_d = target_q;
    end else if (level_q != target_q) begin
      if (ramp_cnt_q == Term) begin
        level_d = (level_q < target_q) ? level_q + 4'd1 : level_q - 4'd1;
      end else begin
        ramp_cnt_d = ramp_cnt_q + CntW'(1);
      end
    end
    busy_d = (level_d != target_d);
  end

  // Ramp state and busy flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q    <= '0;
      ramp_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      level_q    <= level_d;
      ramp_cnt_q <= ramp_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign spi_miso    = miso_sh_q[7];
  assign level_out   = level_q;
  assign target_out  = target_q;
  assign busy        = busy_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule
